regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_write_arbiter_if.sv | 26 ++
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between NREQ requesters and the register-file write arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface regfile_write_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    Req;
    logic [AW*NREQ-1:0] ReqAddr;
    logic [DW*NREQ-1:0] ReqData;
    logic [NREQ-1:0]    Gnt;
    logic [DW-1:0]      WriteData;
    logic [AW-1:0]      WriteAddr;
    logic               WRF;
    logic [15:0]        ConflictCnt;

    modport master (
        output Req, ReqAddr, ReqData,
        input  Gnt, WriteData, WriteAddr, WRF, ConflictCnt
    );

    modport slave (
        input  Req, ReqAddr, ReqData,
        output Gnt, WriteData, WriteAddr, WRF, ConflictCnt
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port; REGARB_CONFLICT_CNT_EN adds a contention counter.
// Latency: Req sampled at edge N -> registered Gnt/WRF/WriteAddr/WriteData during cycle N+1.
// Backpressure: requesters hold Req/addr/data until their one-cycle Gnt pulse; no other stall path.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input logic                   Clk,
    input logic                   Rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int              PW     = $clog2(NREQ);
    localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0]   LAST   = PW'(NREQ - 1);

    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] elig;
    logic            wrf;
    logic [AW-1:0]   waddr;
    logic [DW-1:0]   wdata;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW:0]     idx;
    logic            any;
    logic [AW-1:0]   addr_arr [NREQ];
    logic [DW-1:0]   data_arr [NREQ];

    // A requester granted this cycle is still showing the consumed request; skip it.
    assign elig = bus.Req & ~gnt;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = bus.ReqAddr[AW*i +: AW];
            data_arr[i] = bus.ReqData[DW*i +: DW];
        end
    end

    // Rotating priority search starting at ptr; wrap handled explicitly for non-power-of-2 NREQ.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= NREQ_W) begin
                idx = idx - NREQ_W;
            end
            if (!any && elig[idx[PW-1:0]]) begin
                any = 1'b1;
                win = idx[PW-1:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            gnt   <= '0;
            wrf   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            ptr   <= '0;
        end else if (any) begin
            gnt   <= NREQ'(1) << win;
            waddr <= addr_arr[win];
            wdata <= data_arr[win];
            wrf   <= (addr_arr[win] != '0);
            ptr   <= (win == LAST) ? '0 : win + 1'b1;
        end else begin
            gnt <= '0;
            wrf <= 1'b0;
        end
    end

    assign bus.Gnt       = gnt;
    assign bus.WRF       = wrf;
    assign bus.WriteAddr = waddr;
    assign bus.WriteData = wdata;

`ifdef REGARB_CONFLICT_CNT_EN
    logic [15:0] ccnt;
    logic        multi;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi = |(elig & (elig - NREQ'(1)));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            ccnt <= '0;
        end else if (multi && ccnt != 16'hFFFF) begin
            ccnt <= ccnt + 16'd1;
        end
    end

    assign bus.ConflictCnt = ccnt;
`else
    assign bus.ConflictCnt = 16'h0;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized stimulus for regfile_write_arbiter, checked against a behavioural model.
module tb_regfile_write_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    always #5 Clk = ~Clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    // Stimulus state
    logic [NREQ-1:0] req_v;
    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    // Model state: index of the requester granted this cycle (-1 = none)
    int          m_gnt;
    int          m_ptr;
    logic        m_wrf;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int          m_cnt;

    int vectors = 0;
    int errs    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive();
        bus.Req = req_v;
        for (int i = 0; i < NREQ; i++) begin
            bus.ReqAddr[AW*i +: AW] = addr_a[i];
            bus.ReqData[DW*i +: DW] = data_a[i];
        end
    endtask

    function automatic logic [NREQ-1:0] exp_gnt();
        return (m_gnt < 0) ? '0 : NREQ'(1 << m_gnt);
    endfunction

    // One clock: apply inputs, advance the model, then compare after the edge.
    task automatic do_cycle();
        int n_el;
        int w;
        int idx;
        drive();
        if (Rst) begin
            m_gnt = -1; m_ptr = 0; m_wrf = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
        end else begin
            n_el = 0;
            w    = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (req_v[idx] && idx != m_gnt) begin
                    n_el++;
                    if (w < 0) w = idx;
                end
            end
            if (w >= 0) begin
                m_gnt   = w;
                m_waddr = addr_a[w];
                m_wdata = data_a[w];
                m_wrf   = (addr_a[w] != 0);
                m_ptr   = (w + 1) % NREQ;
            end else begin
                m_gnt = -1;
                m_wrf = 1'b0;
            end
`ifdef REGARB_CONFLICT_CNT_EN
            if (n_el >= 2 && m_cnt < 65535) m_cnt++;
`endif
        end
        @(posedge Clk);
        #1;
        chk("gnt",   32'(bus.Gnt),         32'(exp_gnt()));
        chk("wrf",   32'(bus.WRF),         32'(m_wrf));
        chk("waddr", 32'(bus.WriteAddr),   32'(m_waddr));
        chk("wdata", 32'(bus.WriteData),   32'(m_wdata));
        chk("ccnt",  32'(bus.ConflictCnt), 32'(m_cnt));
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        do_cycle();
        Rst = 1'b0;
    endtask

    initial begin
        m_gnt = -1; m_ptr = 0; m_wrf = 1'b0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
        req_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = AW'(i + 1);
            data_a[i] = 32'hD0 + DW'(i + 1);
        end

        // Reset with all requesting: outputs stay cleared, first grant goes to 0
        Rst   = 1'b1;
        req_v = 3'b111;
        do_cycle();
        do_cycle();
        chk("rst_gnt", 32'(bus.Gnt), 32'h0);
        chk("rst_wrf", 32'(bus.WRF), 32'h0);
        Rst = 1'b0;
        do_cycle();
        chk("first_gnt", 32'(bus.Gnt), 32'h1);

        // Lone requester 1 held: grant every other cycle, then drop on grant
        do_reset();
        req_v = 3'b010; addr_a[1] = 5'h05; data_a[1] = 32'h9A;
        do_cycle();
        chk("single_gnt",   32'(bus.Gnt),       32'h2);
        chk("single_addr",  32'(bus.WriteAddr), 32'h5);
        chk("single_data",  32'(bus.WriteData), 32'h9A);
        do_cycle();
        chk("single_gap",   32'(bus.Gnt),       32'h0);
        do_cycle();
        chk("single_again", 32'(bus.Gnt),       32'h2);
        req_v = 3'b000;
        repeat (3) do_cycle();
        chk("single_drop",  32'(bus.Gnt),       32'h0);

        // Round robin with all three held
        do_reset();
        req_v = 3'b111;
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i] = AW'(i + 1);
            data_a[i] = $urandom;
        end
        for (int c = 0; c < 6; c++) begin
            do_cycle();
            chk("rr_gnt", 32'(bus.Gnt), 32'(1 << (c % 3)));
            chk("rr_wrf", 32'(bus.WRF), 32'h1);
            chk("rr_dat", bus.WriteData, data_a[c % 3]);
        end

        // r0 suppression: granted, no write, pointer wraps to 0
        do_reset();
        req_v = 3'b100; addr_a[2] = 5'h00; data_a[2] = 32'hFE;
        do_cycle();
        chk("r0_gnt", 32'(bus.Gnt), 32'h4);
        chk("r0_wrf", 32'(bus.WRF), 32'h0);
        req_v = 3'b000;
        do_cycle();
        req_v = 3'b111;
        do_cycle();
        chk("r0_next", 32'(bus.Gnt), 32'h1);

        // Reset while a grant is in flight
        do_reset();
        req_v = 3'b001; addr_a[0] = 5'h07;
        do_cycle();
        chk("mid_gnt", 32'(bus.Gnt), 32'h1);
        Rst = 1'b1;
        do_cycle();
        chk("mid_rst_gnt", 32'(bus.Gnt), 32'h0);
        chk("mid_rst_wrf", 32'(bus.WRF), 32'h0);
        Rst = 1'b0;
        do_cycle();
        chk("mid_regnt", 32'(bus.Gnt), 32'h1);

        // Randomized protocol-following requesters
        do_reset();
        req_v = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (m_gnt == i || !req_v[i]) begin
                    if (m_gnt == i && $urandom_range(1, 0) == 0) begin
                        req_v[i] = 1'b0;
                    end else if (m_gnt == i || $urandom_range(2, 0) == 0) begin
                        req_v[i]  = 1'b1;
                        addr_a[i] = ($urandom_range(7, 0) == 0) ? '0 : AW'($urandom);
                        data_a[i] = $urandom;
                    end
                end
            end
            do_cycle();
        end

`ifdef REGARB_CONFLICT_CNT_EN
        // Saturation under continuous contention
        do_reset();
        req_v = 3'b111;
        repeat (65540) do_cycle();
        chk("sat_cnt", 32'(bus.ConflictCnt), 32'hFFFF);
        do_cycle();
        chk("sat_hold", 32'(bus.ConflictCnt), 32'hFFFF);
`else
        chk("cnt_tied", 32'(bus.ConflictCnt), 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
